// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, colour constants and pixel-bundle types for the draw stages
package vga_pkg;
  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  typedef logic [11:0] rgb_t;
  localparam rgb_t BLACK = 12'h000;
  localparam rgb_t GRAY  = 12'h888;
  localparam rgb_t RED   = 12'hf00;
  localparam rgb_t BLUE  = 12'h00f;
  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    rgb_t        rgb;
  } vga_t;
endpackage

// File: rtl/puck_dist.sv
// puck_dist: squared euclidean distance from 6-bit axis magnitudes
module puck_dist (
  input  logic [5:0]  ax,
  input  logic [5:0]  ay,
  output logic [12:0] d2
);
  assign d2 = 13'(ax) * 13'(ax) + 13'(ay) * 13'(ay);
endmodule

// File: rtl/draw_puck.sv
// draw_puck: overlays a rimmed filled disc at a frame-latched centre, 2-cycle timing passthrough
module draw_puck
  import vga_pkg::*;
#(
  parameter int   PUCK_R   = 16,
  parameter int   RIM_W    = 2,
  parameter rgb_t BODY_RGB = 12'h222,
  parameter rgb_t RIM_RGB  = 12'hf00,
  parameter int   RST_X    = 512,
  parameter int   RST_Y    = 384
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  input  logic [10:0] xpos_in,
  input  logic [10:0] ypos_in,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out
);
  localparam logic [12:0] BODY2 = 13'((PUCK_R - RIM_W) * (PUCK_R - RIM_W));
  localparam logic [12:0] RIM2  = 13'(PUCK_R * PUCK_R);
  logic        vblnk_prev_q, vblnk_prev_d;
  logic [10:0] cx_q, cx_d, cy_q, cy_d;
  logic [11:0] dx, dy;
  logic [10:0] adx_q, adx_d, ady_q, ady_d;
  logic        near_q, near_d, in_box;
  logic [12:0] d2;
  vga_t        s1_q, s1_d, s2_q, s2_d;
  puck_dist u_dist (.ax(adx_q[5:0]), .ay(ady_q[5:0]), .d2(d2));
  // next-state: frame-synchronous centre latch, distance stage, colour select
  always_comb begin
    vblnk_prev_d = vblnk_in;
    cx_d = (vblnk_in && !vblnk_prev_q) ? xpos_in : cx_q;
    cy_d = (vblnk_in && !vblnk_prev_q) ? ypos_in : cy_q;
    dx = {1'b0, hcount_in} - {1'b0, cx_q};
    dy = {1'b0, vcount_in} - {1'b0, cy_q};
    adx_d = dx[11] ? 11'(-dx) : dx[10:0];
    ady_d = dy[11] ? 11'(-dy) : dy[10:0];
    near_d = (adx_d <= 11'(PUCK_R)) && (ady_d <= 11'(PUCK_R));
    s1_d = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, r_in, g_in, b_in};
    in_box = near_q && ~|{adx_q[10:6], ady_q[10:6]};
    s2_d = s1_q;
    s2_d.rgb = (s1_q.hblnk || s1_q.vblnk) ? s1_q.rgb :
               (in_box && d2 <= BODY2)    ? BODY_RGB :
               (in_box && d2 <= RIM2)     ? RIM_RGB  : s1_q.rgb;
  end
  // state and pipeline registers, cleared asynchronously
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_q <= 1'b0;
      cx_q <= 11'(RST_X);
      cy_q <= 11'(RST_Y);
      adx_q <= '0;
      ady_q <= '0;
      near_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      adx_q <= adx_d;
      ady_q <= ady_d;
      near_q <= near_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign hcount_out = s2_q.hcount;
  assign hsync_out = s2_q.hsync;
  assign hblnk_out = s2_q.hblnk;
  assign vcount_out = s2_q.vcount;
  assign vsync_out = s2_q.vsync;
  assign vblnk_out = s2_q.vblnk;
  assign {r_out, g_out, b_out} = s2_q.rgb;
endmodule
